div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Operand front-end for the 8-bit restoring divider: sits directly upstream of it and drives its A/B/in_valid inputs.
- Buffers operand pairs from a valid/ready producer in a small FIFO and issues exactly one division at a time.
- Captures the divider's one-cycle quotient/remainder pulse and re-presents it on a valid/ready result port with the operand tag.
- Resolves divide-by-zero locally without issuing to the divider.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TAG_W, 4, width of the tag carried from operand to result
TIMEOUT, 32, WAIT-state cycle limit (used only with DIV_WDOG_EN)

Ports:
clk1  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  FIFO can accept; equals !full
s_a  in  8  dividend
s_b  in  8  divisor
s_tag  in  TAG_W  operand tag
div_a  out  8  to divider A
div_b  out  8  to divider B
div_in_valid  out  1  to divider in_valid
div_out_valid  in  1  divider result pulse
div_quotient  in  8  divider quotient
div_remainder  in  8  divider remainder
m_valid  out  1  result valid
m_ready  in  1  result accepted
m_quotient  out  8  result quotient
m_remainder  out  8  result remainder
m_tag  out  TAG_W  tag of the result
m_div0  out  1  result came from a zero divisor
m_timeout  out  1  watchdog error flag; tied 0 without DIV_WDOG_EN
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: all outputs 0 except s_ready=1. Reset clears FIFO pointers, the FSM (to IDLE), and the watchdog counter.
- Push: s_valid && s_ready. Pop: performed only by the FSM.
  - Push and pop in the same cycle keep level unchanged.
  - When full, s_ready=0 and no push occurs, even if a pop happens that cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, FIFO non-empty, head b==0:
  - Pop the head and load the result: quotient=8'hFF, remainder=head a, tag, m_div0=1.
  - Set m_valid=1 and go to HOLD. The divider is never pulsed.
- IDLE, FIFO non-empty, head b!=0:
  - Pop the head and register div_a/div_b and the tag.
  - Set div_in_valid=1 and go to ISSUE.
- ISSUE: lasts exactly one cycle. Clear div_in_valid, go to WAIT.
  - div_in_valid is therefore a single-cycle pulse.
  - div_a/div_b hold their values until the next issue, so the divider's sampling is safe.
- WAIT: on div_out_valid, capture div_quotient/div_remainder (sampled in the pulse cycle), set m_div0=0 and m_valid=1, go to HOLD.
- HOLD: m_* outputs stay stable while m_valid && !m_ready. When m_ready=1, clear m_valid and go to IDLE.
  - The next pop happens at the earliest one cycle later (no overlap).
- div_out_valid outside WAIT is ignored.
- Latency, s_valid to div_in_valid with an empty FIFO and the FSM in IDLE: 2 cycles (push, then pop/load).
- Only one division is ever outstanding, and div_in_valid is never asserted outside ISSUE.
- Reset mid-operation (any state): the result and any in-flight division are discarded, and m_valid drops the cycle after rst.
  - The top level drives the divider's rst_n from ~rst, so both blocks restart together.

Optional Feature:
- Macro DIV_WDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT with no div_out_valid: load the result quotient=0, remainder=0, tag, m_timeout=1, m_div0=0, set m_valid=1, go to HOLD.
  - div_out_valid and count==TIMEOUT in the same cycle: the real result wins and m_timeout=0.
- Not defined: no counter is built, m_timeout is tied 0, and WAIT waits indefinitely.

Test Plan:
- Push a=100, b=7, tag=3 with a behavioural divider model -> one div_in_valid pulse with div_a=100, div_b=7; result m_quotient=14, m_remainder=2, m_tag=3, m_div0=0.
- Push a=200, b=0, tag=5 -> no div_in_valid; m_quotient=8'hFF, m_remainder=200, m_div0=1 within 2 cycles of the pop.
- Hold m_ready=0 and push 6 ops back-to-back -> s_ready=0 once level=4 (one op in flight); m_* stable while held; after release, results emerge in push order (tags 0..5).
- m_ready=0 for 10 cycles after m_valid -> m_* unchanged; no second div_in_valid until the handshake completes.
- With DIV_WDOG_EN and div_out_valid forced 0, push a=9, b=3 -> m_valid with m_timeout=1, quotient=0, remainder=0 on WAIT cycle 32; the next op issues normally.
- Assert rst for 1 cycle while in WAIT with 2 ops queued -> level=0, m_valid=0, s_ready=1; a late div_out_valid is ignored; a fresh op 50/6 returns 8 r 2.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: operand FIFO and single-issue front-end for the 8-bit restoring divider (optional watchdog: DIV_WDOG_EN)
module div_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_a,
    input  logic [7:0]               s_b,
    input  logic [TAG_W-1:0]         s_tag,
    output logic [7:0]               div_a,
    output logic [7:0]               div_b,
    output logic                     div_in_valid,
    input  logic                     div_out_valid,
    input  logic [7:0]               div_quotient,
    input  logic [7:0]               div_remainder,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_quotient,
    output logic [7:0]               m_remainder,
    output logic [TAG_W-1:0]         m_tag,
    output logic                     m_div0,
    output logic                     m_timeout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_nxt;
    logic [7:0]       fifo_a   [DEPTH];
    logic [7:0]       fifo_b   [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [TAG_W-1:0] cur_tag;
    logic push, pop, full, empty, head_zero, timeout_hit;
    logic load_div0, issue, load_res, load_to, release_res;

    assign full      = level == (AW+1)'(DEPTH);
    assign empty     = level == '0;
    assign s_ready   = !full;
    assign push      = s_valid && !full;
    assign head_zero = fifo_b[rd_ptr] == 8'd0;

    // Operand storage; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk1) begin
        if (push) begin
            fifo_a[wr_ptr]   <= s_a;
            fifo_b[wr_ptr]   <= s_b;
            fifo_tag[wr_ptr] <= s_tag;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef DIV_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    // Watchdog counts WAIT cycles; the increment that reaches TIMEOUT forces a timeout result
    always_ff @(posedge clk1) begin
        if (rst)
            wd_cnt <= '0;
        else
            wd_cnt <= state == ISSUE ? '0 : state == WAIT ? wd_cnt + 1'b1 : wd_cnt;
    end
    assign timeout_hit = state == WAIT && wd_cnt == CW'(TIMEOUT - 1);
    // Timeout flag travels with the result it describes
    always_ff @(posedge clk1) begin
        if (rst)
            m_timeout <= 1'b0;
        else
            m_timeout <= load_to ? 1'b1 : (load_res || load_div0) ? 1'b0 : m_timeout;
    end
`else
    assign timeout_hit = TIMEOUT < 0;
    assign m_timeout   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk1) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a real divider result takes priority over a simultaneous timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = empty ? IDLE : head_zero ? HOLD : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = (div_out_valid || timeout_hit) ? HOLD : WAIT;
            HOLD:  state_nxt = m_ready ? IDLE : HOLD;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        pop         = state == IDLE && !empty;
        load_div0   = pop && head_zero;
        issue       = pop && !head_zero;
        load_res    = state == WAIT && div_out_valid;
        load_to     = state == WAIT && !div_out_valid && timeout_hit;
        release_res = state == HOLD && m_ready;
    end

    // Divider operands and result holding registers
    always_ff @(posedge clk1) begin
        if (rst) begin
            div_a        <= '0;
            div_b        <= '0;
            div_in_valid <= 1'b0;
            cur_tag      <= '0;
            m_valid      <= 1'b0;
            m_quotient   <= '0;
            m_remainder  <= '0;
            m_tag        <= '0;
            m_div0       <= 1'b0;
        end else begin
            div_in_valid <= issue;
            if (issue) begin
                div_a   <= fifo_a[rd_ptr];
                div_b   <= fifo_b[rd_ptr];
                cur_tag <= fifo_tag[rd_ptr];
            end
            if (load_div0) begin
                m_quotient  <= 8'hFF;
                m_remainder <= fifo_a[rd_ptr];
                m_tag       <= fifo_tag[rd_ptr];
                m_div0      <= 1'b1;
                m_valid     <= 1'b1;
            end
            if (load_res || load_to) begin
                m_quotient  <= load_res ? div_quotient : 8'd0;
                m_remainder <= load_res ? div_remainder : 8'd0;
                m_tag       <= cur_tag;
                m_div0      <= 1'b0;
                m_valid     <= 1'b1;
            end
            if (release_res)
                m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed bench with divider model and result scoreboard
module tb_div_issue_ctrl;
    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, m_ready = 1'b1;
    logic       s_ready, div_in_valid, div_out_valid, m_valid, m_div0, m_timeout;
    logic [7:0] s_a = '0, s_b = '0, div_a, div_b, m_quotient, m_remainder;
    logic [3:0] s_tag = '0, m_tag;
    logic [2:0] level;
    logic [7:0] dq = '0, dr = '0, ma = '0, mb = '0;
    logic       dv_model = 1'b0, inj = 1'b0, model_en = 1'b1;
    int         mcnt = 0, n_issue = 0, n_chk = 0, n_fail = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic [3:0] tag;
        logic       div0;
        logic       to;
    } res_t;
    res_t sb[$];

    always #5 clk1 = ~clk1;

    div_issue_ctrl #(.DEPTH(4), .TAG_W(4), .TIMEOUT(32)) dut (
        .clk1(clk1), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_tag(s_tag), .div_a(div_a), .div_b(div_b),
        .div_in_valid(div_in_valid), .div_out_valid(div_out_valid),
        .div_quotient(dq), .div_remainder(dr), .m_valid(m_valid), .m_ready(m_ready),
        .m_quotient(m_quotient), .m_remainder(m_remainder), .m_tag(m_tag),
        .m_div0(m_div0), .m_timeout(m_timeout), .level(level)
    );

    assign div_out_valid = dv_model | inj;

    // Behavioural divider: result pulse four cycles after the issue pulse
    always @(posedge clk1) begin
        if (div_in_valid) n_issue <= n_issue + 1;
        if (rst) begin
            mcnt     <= 0;
            dv_model <= 1'b0;
        end else begin
            dv_model <= model_en && mcnt == 1;
            if (mcnt == 1) begin
                dq <= ma / mb;
                dr <= ma % mb;
            end
            if (div_in_valid) begin
                ma   <= div_a;
                mb   <= div_b;
                mcnt <= 3;
            end else if (mcnt != 0) mcnt <= mcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every accepted result is compared against the scoreboard head
    always @(negedge clk1) begin
        res_t e;
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_result: observed tag %0h expected none", m_tag);
                end
            end else begin
                e = sb.pop_front();
                chk($sformatf("res_q_tag%0d", e.tag), m_quotient, e.q);
                chk($sformatf("res_r_tag%0d", e.tag), m_remainder, e.r);
                chk($sformatf("res_tag_tag%0d", e.tag), m_tag, e.tag);
                chk($sformatf("res_div0_tag%0d", e.tag), m_div0, e.div0);
                chk($sformatf("res_to_tag%0d", e.tag), m_timeout, e.to);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t, input bit exp_res);
        int  k = 0;
        bit  ok;
        if (exp_res) sb.push_back(b == 0 ? res_t'({8'hFF, a, t, 2'b10}) : res_t'({a / b, a % b, t, 2'b00}));
        s_a = a; s_b = b; s_tag = t; s_valid = 1'b1;
        do begin
            @(negedge clk1);
            ok = s_ready;
            @(posedge clk1);
            #1;
            k++;
        end while (!ok && k < 200);
        s_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 500) begin
            cyc(1);
            k++;
        end
        chk("drain_empty", sb.size(), 0);
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int i0;
        int k;
        cyc(3);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_div_in_valid", div_in_valid, 0);
        chk("rst_m_div0", m_div0, 0);
        chk("rst_m_timeout", m_timeout, 0);
        chk("rst_m_quotient", m_quotient, 0);
        rst = 1'b0;
        cyc(1);

        i0 = n_issue;
        push(8'd100, 8'd7, 4'd3, 1);
        cyc(1);
        chk("issue_latency", div_in_valid, 1);
        chk("issue_div_a", div_a, 100);
        chk("issue_div_b", div_b, 7);
        cyc(1);
        chk("issue_pulse_end", div_in_valid, 0);
        drain();
        chk("issue_count_1", n_issue - i0, 1);
        chk("div_a_held", div_a, 100);

        i0 = n_issue;
        push(8'd200, 8'd0, 4'd5, 1);
        cyc(1);
        chk("div0_m_valid", m_valid, 1);
        chk("div0_flag", m_div0, 1);
        chk("div0_quotient", m_quotient, 8'hFF);
        chk("div0_remainder", m_remainder, 200);
        drain();
        chk("div0_no_issue", n_issue - i0, 0);

        m_ready = 1'b0;
        i0 = n_issue;
        for (int i = 0; i < 5; i++) push(8'(51 + 13 * i), 8'(i + 2), 4'(i), 1);
        chk("full_level", level, 4);
        chk("full_s_ready", s_ready, 0);
        s_a = 8'd116; s_b = 8'd7; s_tag = 4'd5; s_valid = 1'b1;
        cyc(3);
        chk("full_no_push", level, 4);
        s_valid = 1'b0;
        k = 0;
        while (!m_valid && k < 50) begin
            cyc(1);
            k++;
        end
        chk("hold_m_valid", m_valid, 1);
        cyc(10);
        chk("hold_valid_stable", m_valid, 1);
        chk("hold_q_stable", m_quotient, 25);
        chk("hold_r_stable", m_remainder, 1);
        chk("hold_tag_stable", m_tag, 0);
        chk("hold_single_issue", n_issue - i0, 1);
        m_ready = 1'b1;
        push(8'd116, 8'd7, 4'd5, 1);
        drain();
        chk("burst_issue_count", n_issue - i0, 6);

        model_en = 1'b0;
        push(8'd40, 8'd4, 4'd1, 0);
        push(8'd41, 8'd4, 4'd2, 0);
        push(8'd42, 8'd4, 4'd3, 0);
        cyc(2);
        chk("wait_queued_level", level, 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_level", level, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_s_ready", s_ready, 1);
        i0 = n_issue;
        inj = 1'b1;
        cyc(1);
        inj = 1'b0;
        cyc(3);
        chk("late_pulse_ignored", m_valid, 0);
        chk("midrst_no_issue", n_issue - i0, 0);
        model_en = 1'b1;
        push(8'd50, 8'd6, 4'd9, 1);
        drain();
        chk("post_rst_div_a", div_a, 50);

`ifdef DIV_WDOG_EN
        model_en = 1'b0;
        i0 = n_issue;
        sb.push_back(res_t'({8'd0, 8'd0, 4'd1, 2'b01}));
        push(8'd9, 8'd3, 4'd1, 0);
        cyc(1);
        k = 0;
        while (!m_valid && k < 100) begin
            cyc(1);
            k++;
        end
        chk("wdog_cycles", k, 33);
        drain();
        model_en = 1'b1;
        push(8'd9, 8'd3, 4'd2, 1);
        drain();
        chk("wdog_next_issue", n_issue - i0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
